// File: rtl/audio_pkg.sv
// Shared types, constants and the output saturator for the audio gain stage.
package audio_pkg;

  typedef logic signed [23:0] sample_t;
  typedef logic [9:0]         gain_t;
  typedef logic signed [34:0] product_t;

  localparam int      GAIN_FRAC_BITS = 8;
  localparam sample_t SAMPLE_MAX     = 24'sh7FFFFF;
  localparam sample_t SAMPLE_MIN     = 24'sh800000;

  localparam product_t PRODUCT_MAX = product_t'(SAMPLE_MAX);
  localparam product_t PRODUCT_MIN = product_t'(SAMPLE_MIN);

  // Clamp a scaled product back into the 24-bit sample range.
  function automatic sample_t saturate(input product_t value);
    sample_t result;
    if (value > PRODUCT_MAX) begin
      result = SAMPLE_MAX;
    end else if (value < PRODUCT_MIN) begin
      result = SAMPLE_MIN;
    end else begin
      result = value[23:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             rise_q;
  logic [CNT_W-1:0] count_q;

  // The level flips only once the synchronized input has disagreed with it
  // for DEBOUNCE_CYCLES samples in a row; any agreeing sample restarts the count.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= i_button;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        count_q <= '0;
      end else if (count_q == LAST_COUNT) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/audio_gain_stage.sv
// Button-controlled, ramped digital volume stage with 2-cycle saturating datapath.
// Optional soft mute (i_mute port) is enabled by defining AUDIO_GAIN_SOFT_MUTE_EN.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH      = 24,
  parameter int GAIN_STEPS      = 32,
  parameter int UNITY_INDEX     = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic signed [DATA_WIDTH-1:0] i_data_left,
  input  logic signed [DATA_WIDTH-1:0] i_data_right,
  input  logic                         i_data_valid,
  input  logic                         i_btn_up,
  input  logic                         i_btn_down,
`ifdef AUDIO_GAIN_SOFT_MUTE_EN
  input  logic                         i_mute,
`endif
  output logic        [DATA_WIDTH-1:0] o_data_left,
  output logic        [DATA_WIDTH-1:0] o_data_right,
  output logic                         o_data_valid,
  output logic        [4:0]            o_gain_index
);

  localparam logic [4:0] MAX_INDEX   = 5'(GAIN_STEPS - 1);
  localparam logic [4:0] RESET_INDEX = 5'(UNITY_INDEX);
  localparam gain_t      RESET_GAIN  = gain_t'(UNITY_INDEX * 16);

  logic upRise, downRise;
  // Only the debounced edges drive the index; the levels are left unused.
  logic unusedUpLevel, unusedDownLevel;

  logic [4:0] index_q, index_d;
  gain_t      targetGain;
  gain_t      appliedGain_q, appliedGain_d;

  product_t prodLeft_q,  prodLeft_d;
  product_t prodRight_q, prodRight_d;
  logic     stage1Valid_q;
  sample_t  outLeft_q, outRight_q;
  logic     outValid_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce_up (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_button(i_btn_up),
    .o_level (unusedUpLevel),
    .o_rise  (upRise)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce_down (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_button(i_btn_down),
    .o_level (unusedDownLevel),
    .o_rise  (downRise)
  );

  // Simultaneous up and down edges cancel; the index clamps at both ends.
  always_comb begin
    index_d = index_q;
    if (upRise && !downRise && (index_q != MAX_INDEX)) begin
      index_d = index_q + 5'd1;
    end else if (downRise && !upRise && (index_q != 5'd0)) begin
      index_d = index_q - 5'd1;
    end
  end

  always_comb begin
    targetGain = {1'b0, index_q, 4'b0000};
`ifdef AUDIO_GAIN_SOFT_MUTE_EN
    if (i_mute) begin
      targetGain = '0;
    end
`endif
    appliedGain_d = appliedGain_q;
    if (i_data_valid) begin
      if (appliedGain_q < targetGain) begin
        appliedGain_d = appliedGain_q + gain_t'(1);
      end else if (appliedGain_q > targetGain) begin
        appliedGain_d = appliedGain_q - gain_t'(1);
      end
    end
  end

  // Stage 1 multiplies with the gain in force before this frame's ramp step.
  always_comb begin
    prodLeft_d  = product_t'(i_data_left)  * product_t'($signed({1'b0, appliedGain_q}));
    prodRight_d = product_t'(i_data_right) * product_t'($signed({1'b0, appliedGain_q}));
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      index_q       <= RESET_INDEX;
      appliedGain_q <= RESET_GAIN;
    end else begin
      index_q       <= index_d;
      appliedGain_q <= appliedGain_d;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      prodLeft_q    <= '0;
      prodRight_q   <= '0;
      stage1Valid_q <= 1'b0;
      outLeft_q     <= '0;
      outRight_q    <= '0;
      outValid_q    <= 1'b0;
    end else begin
      stage1Valid_q <= i_data_valid;
      if (i_data_valid) begin
        prodLeft_q  <= prodLeft_d;
        prodRight_q <= prodRight_d;
      end
      outValid_q <= stage1Valid_q;
      if (stage1Valid_q) begin
        outLeft_q  <= saturate(prodLeft_q  >>> GAIN_FRAC_BITS);
        outRight_q <= saturate(prodRight_q >>> GAIN_FRAC_BITS);
      end
    end
  end

  assign o_data_left  = outLeft_q;
  assign o_data_right = outRight_q;
  assign o_data_valid = outValid_q;
  assign o_gain_index = index_q;

endmodule

// File: tb/tb_audio_gain_stage.sv
// Self-checking bench for audio_gain_stage: frame-level gain model plus directed literal checks.
module tb_audio_gain_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] dataLeft, dataRight;
  logic        dataValid;
  logic        btnUp, btnDown;
  logic [23:0] outLeft, outRight;
  logic        outValid;
  logic [4:0]  gainIndex;
`ifdef AUDIO_GAIN_SOFT_MUTE_EN
  logic        mute = 1'b0;
`endif

  always #5 clock = ~clock;

  audio_gain_stage #(
    .DATA_WIDTH     (24),
    .GAIN_STEPS     (32),
    .UNITY_INDEX    (16),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_data_left (dataLeft),
    .i_data_right(dataRight),
    .i_data_valid(dataValid),
    .i_btn_up    (btnUp),
    .i_btn_down  (btnDown),
`ifdef AUDIO_GAIN_SOFT_MUTE_EN
    .i_mute      (mute),
`endif
    .o_data_left (outLeft),
    .o_data_right(outRight),
    .o_data_valid(outValid),
    .o_gain_index(gainIndex)
  );

  typedef struct {
    int          due;
    logic [23:0] left;
    logic [23:0] right;
  } expected_t;

  expected_t expQ[$];
  int  cycleCount = 0;
  int  checks = 0;
  int  passes = 0;
  int  modelGain = 256;
  int  modelIndex = 16;
  bit  modelMute = 1'b0;

  // Volume rule: sample * gain / 256, rounded toward -inf, clamped to 24 bits.
  function automatic logic [23:0] scale(input logic [23:0] x, input int gain);
    longint v;
    logic [23:0] r;
    v = longint'($signed(x)) * longint'(gain);
    v = v >>> 8;
    if (v > 64'sd8388607) v = 64'sd8388607;
    if (v < -64'sd8388608) v = -64'sd8388608;
    r = v[23:0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
    int target;
    expected_t e;
    @(negedge clock);
    dataLeft  = l;
    dataRight = r;
    dataValid = 1'b1;
    e.due   = cycleCount + 2;
    e.left  = scale(l, modelGain);
    e.right = scale(r, modelGain);
    expQ.push_back(e);
    target = modelMute ? 0 : modelIndex * 16;
    if (modelGain < target) modelGain++;
    else if (modelGain > target) modelGain--;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      dataValid = 1'b0;
    end
  endtask

  task automatic holdButtons(input logic up, input logic down, input int n);
    @(negedge clock);
    dataValid = 1'b0;
    btnUp     = up;
    btnDown   = down;
    repeat (n) @(negedge clock);
  endtask

  task automatic pressUp();
    holdButtons(1'b1, 1'b0, 40);
    holdButtons(1'b0, 1'b0, 40);
    if (modelIndex < 31) modelIndex++;
  endtask

  task automatic pressDown();
    holdButtons(1'b0, 1'b1, 40);
    holdButtons(1'b0, 1'b0, 40);
    if (modelIndex > 0) modelIndex--;
  endtask

  // Every cycle: output valid must appear exactly 2 cycles after each input frame.
  always @(posedge clock) begin
    bit expValid;
    cycleCount++;
    #1;
    while (expQ.size() > 0 && expQ[0].due < cycleCount) begin
      checkOutput("missed_frame", 32'(expQ[0].due), 32'(cycleCount));
      void'(expQ.pop_front());
    end
    expValid = (expQ.size() > 0) && (expQ[0].due == cycleCount);
    checkOutput("out_valid", 32'(outValid), 32'(expValid));
    if (expValid) begin
      checkOutput("model_left", 32'(outLeft), 32'(expQ[0].left));
      checkOutput("model_right", 32'(outRight), 32'(expQ[0].right));
      void'(expQ.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    dataLeft = '0; dataRight = '0; dataValid = 1'b0;
    btnUp = 1'b0; btnDown = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_valid", 32'(outValid), 32'd0);
    checkOutput("reset_left", 32'(outLeft), 32'd0);
    checkOutput("reset_right", 32'(outRight), 32'd0);
    checkOutput("reset_index", 32'(gainIndex), 32'd16);
    reset = 1'b0;
    idle(2);

    $display("[TB] unity pass-through");
    applyStimulus(24'h100000, 24'hF00000);
    idle(3);
    checkOutput("unity_left", 32'(outLeft), 32'h100000);
    checkOutput("unity_right", 32'(outRight), 32'hF00000);

    $display("[TB] bouncing up button");
    for (int i = 0; i < 40; i++) holdButtons(i % 2 == 0, 1'b0, 5);
    holdButtons(1'b1, 1'b0, 40);
    holdButtons(1'b0, 1'b0, 40);
    modelIndex = 17;
    checkOutput("bounce_index", 32'(gainIndex), 32'd17);

    $display("[TB] ramp 256 -> 272");
    repeat (16) applyStimulus(24'h010000, 24'h010000);
    applyStimulus(24'h010000, 24'h010000);
    idle(3);
    checkOutput("ramp_left", 32'(outLeft), 32'h011000);

    $display("[TB] simultaneous up and down");
    holdButtons(1'b1, 1'b1, 40);
    holdButtons(1'b0, 1'b0, 40);
    checkOutput("both_index", 32'(gainIndex), 32'd17);

    $display("[TB] index to top and saturation");
    repeat (14) pressUp();
    checkOutput("top_index", 32'(gainIndex), 32'd31);
    pressUp();
    checkOutput("top_hold_index", 32'(gainIndex), 32'd31);
    repeat (230) applyStimulus(24'h7FFFFF, 24'h800000);
    idle(3);
    checkOutput("sat_left", 32'(outLeft), 32'h7FFFFF);
    checkOutput("sat_right", 32'(outRight), 32'h800000);

    $display("[TB] index to bottom");
    repeat (33) pressDown();
    checkOutput("bottom_index", 32'(gainIndex), 32'd0);

    $display("[TB] back-to-back frames");
    applyStimulus(24'h000123, 24'hFFFF00);
    applyStimulus(24'h200000, 24'hE00000);
    applyStimulus(24'h012345, 24'h7FFFFF);
    idle(4);
    checkOutput("b2b_last_left", 32'(outLeft), 32'h02320F);

    $display("[TB] reset mid-stream");
    applyStimulus(24'h300000, 24'h300000);
    @(negedge clock);
    dataValid = 1'b0;
    reset = 1'b1;
    expQ.delete();
    modelGain = 256;
    modelIndex = 16;
    repeat (2) @(negedge clock);
    checkOutput("midrst_valid", 32'(outValid), 32'd0);
    checkOutput("midrst_left", 32'(outLeft), 32'd0);
    checkOutput("midrst_index", 32'(gainIndex), 32'd16);
    reset = 1'b0;
    idle(3);
    applyStimulus(24'h123456, 24'hEDCBAA);
    idle(3);
    checkOutput("postrst_left", 32'(outLeft), 32'h123456);

`ifdef AUDIO_GAIN_SOFT_MUTE_EN
    $display("[TB] soft mute");
    mute = 1'b1;
    modelMute = 1'b1;
    repeat (260) applyStimulus(24'h100000, 24'hF00000);
    idle(3);
    checkOutput("mute_left", 32'(outLeft), 32'd0);
    checkOutput("mute_index", 32'(gainIndex), 32'd16);
    mute = 1'b0;
    modelMute = 1'b0;
    repeat (260) applyStimulus(24'h100000, 24'hF00000);
    idle(3);
    checkOutput("unmute_left", 32'(outLeft), 32'h100000);
`endif

    idle(5);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/audio_gain_stage.md
Name: audio_gain_stage

Overview:
- Per-frame digital volume stage between monitor_controller and audio_serializer.
- Takes the stereo 24-bit parallel sample pair plus its valid strobe and applies a button-controlled gain to both channels.
- Gain changes are ramped to avoid zipper noise; results are saturated to 24 bits and passed on to the serializer.

Parameters:
- DATA_WIDTH, 24, signed sample width per channel.
- GAIN_STEPS, 32, number of user gain indices (0..GAIN_STEPS-1).
- UNITY_INDEX, 16, reset gain index; index*16 = 256 = unity in Q2.8.
- DEBOUNCE_CYCLES, 1000000, i_clock cycles a button must be stable before its level is accepted.

Ports:
- i_clock  in  1  system clock; all logic in this domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_data_left  in  DATA_WIDTH  signed left sample.
- i_data_right  in  DATA_WIDTH  signed right sample.
- i_data_valid  in  1  one-cycle strobe, sample pair valid.
- i_btn_up  in  1  raw volume-up button, asynchronous.
- i_btn_down  in  1  raw volume-down button, asynchronous.
- o_data_left  out  DATA_WIDTH  scaled left sample.
- o_data_right  out  DATA_WIDTH  scaled right sample.
- o_data_valid  out  1  one-cycle strobe, output pair valid.
- o_gain_index  out  5  current target gain index.

Behaviour:
- Reset (asynchronous, active-high):
  - o_data_left/right = 0, o_data_valid = 0.
  - o_gain_index = UNITY_INDEX.
  - Applied gain = 256; pipeline and debouncers cleared.
  - Reset mid-stream drops in-flight samples; no valid pulse is emitted for them.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - A rising edge of debounced up increments the index; down decrements it.
  - The index saturates at 0 and GAIN_STEPS-1 with no wrap.
  - Rising edges of up and down in the same cycle: index unchanged.
- Gain ramp:
  - target_gain = index*16, 10-bit unsigned Q2.8 (max 496).
  - applied_gain moves 1 LSB toward target_gain on each cycle with i_data_valid=1; it holds otherwise.
  - A full index step therefore takes 16 frames.
  - Index changes mid-ramp simply retarget the ramp.
- Datapath, fully pipelined, latency 2 cycles from i_data_valid to o_data_valid:
  - Stage 1: on i_data_valid, each channel sample (signed) is multiplied by {1'b0, applied_gain} (signed 11-bit) into a 35-bit product.
    - The pre-update applied_gain is used; the ramp update takes effect on the next sample.
    - A valid flag is registered alongside.
  - Stage 2: product arithmetic-shifted right 8 (truncate toward -inf), then saturated to [-2^23, 2^23-1].
    - Outputs register only when stage-1 valid is set; otherwise o_data_left/right hold their last value.
  - o_data_valid = stage-2 valid, one cycle wide.
  - Back-to-back i_data_valid on consecutive cycles is supported; no back-pressure.
- Both channels always share the same applied_gain for a given sample pair.

Optional Feature:
- Macro AUDIO_GAIN_SOFT_MUTE_EN.
- Defined:
  - Adds input port i_mute (1 bit, synchronous level).
  - While i_mute=1, the effective ramp target is 0 and o_gain_index is still reported.
  - On release, the ramp returns to index*16 at the same 1-LSB-per-frame rate.
  - Index buttons still operate while muted.
- Undefined: no i_mute port; the ramp target is always index*16.

Decomposition:
- Package audio_pkg:
  - typedef sample_t (logic signed [23:0]) and gain_t (logic [9:0]).
  - Constants GAIN_FRAC_BITS=8, SAMPLE_MAX, SAMPLE_MIN.
- Sub-module button_debouncer (i_clock, i_reset, i_button, o_level, o_rise):
  - Contains synchronizer, counter and edge detect.
  - Instantiated twice.

Test Plan:
- Reset then i_data_valid with L=0x100000, R=0xF00000 -> 2 cycles later o_data_valid=1, L=0x100000, R=0xF00000 (unity); o_gain_index=16.
- Up pressed and held > DEBOUNCE_CYCLES (bench DEBOUNCE_CYCLES=16) -> o_gain_index=17; applied gain rises 256->272 over 16 frames; input 0x010000 gives output 0x011000 after the 16th frame.
- Index driven to 31, input L=0x7FFFFF, gain ramped to 496 -> output saturates at 0x7FFFFF; input 0x800000 saturates at 0x800000; further up presses keep index 31.
- Bouncing up button (toggle every 5 cycles for 200 cycles, then stable high) -> exactly one increment; up and down edges in the same cycle -> no change.
- Valid on 3 consecutive cycles -> 3 consecutive output valids, in order; assert i_reset between stage 1 and stage 2 -> no valid emitted, outputs 0, gain 256.
- With AUDIO_GAIN_SOFT_MUTE_EN: i_mute=1 at unity -> output magnitude falls linearly to 0 after 256 frames; release -> returns to unity after 256 frames.
